// File: rtl/rs_pkg.sv
// Shared types and constants for the reservation station bank: entry record,
// reserved "operand valid" tag and the CDB tag-match helper.
package rs_pkg;

   localparam int ALU_OP_WIDTH = 3;
   localparam int RS_XLEN      = 32;
   localparam int RS_TAG_WIDTH = 32;

   localparam logic [RS_TAG_WIDTH-1:0] TAG_NONE = '0;

   typedef struct packed {
      logic                    busy;
      logic [RS_TAG_WIDTH-1:0] q1;
      logic [RS_XLEN-1:0]      v1;
      logic [RS_TAG_WIDTH-1:0] q2;
      logic [RS_XLEN-1:0]      v2;
      logic [ALU_OP_WIDTH-1:0] op;
      logic                    sign;
      logic [RS_TAG_WIDTH-1:0] rob;
   } rs_entry_t;

   // Tag 0 means the operand is already present, so it must never match the CDB.
   function automatic logic tagHit(input logic                    cdbActive,
                                   input logic [RS_TAG_WIDTH-1:0] waitTag,
                                   input logic [RS_TAG_WIDTH-1:0] cdbTag);
      return cdbActive && (waitTag != TAG_NONE) && (waitTag == cdbTag);
   endfunction

endpackage

// File: rtl/reservation_station_bank_if.sv
// Dispatch / CDB / functional-unit bundle of the reservation station bank.
// The master side is the issuer and FU; the slave side is the bank itself.
interface reservation_station_bank_if #(
   parameter int XLEN      = 32,
   parameter int TAG_WIDTH = 32,
   parameter int DEPTH     = 4
);
   import rs_pkg::*;

   localparam int COUNT_WIDTH = $clog2(DEPTH + 1);

   logic                    enable;
   logic [TAG_WIDTH-1:0]    q1_in;
   logic [TAG_WIDTH-1:0]    q2_in;
   logic [XLEN-1:0]         v1_in;
   logic [XLEN-1:0]         v2_in;
   logic [ALU_OP_WIDTH-1:0] alu_op_in;
   logic                    alu_sign_in;
   logic [TAG_WIDTH-1:0]    reorder_buffer_tag_in;
   logic                    flush;
   logic                    cdb_active;
   logic [TAG_WIDTH-1:0]    cdb_tag;
   logic [XLEN-1:0]         cdb_data;
   logic                    dispatched_in;

   logic [XLEN-1:0]         v1_out;
   logic [XLEN-1:0]         v2_out;
   logic [ALU_OP_WIDTH-1:0] alu_op_out;
   logic                    alu_sign_out;
   logic [TAG_WIDTH-1:0]    reorder_buffer_tag_out;
   logic                    ready_to_execute;
   logic                    full;
   logic [COUNT_WIDTH-1:0]  busy_count;

   modport master (
      output enable, q1_in, q2_in, v1_in, v2_in, alu_op_in, alu_sign_in,
             reorder_buffer_tag_in, flush, cdb_active, cdb_tag, cdb_data,
             dispatched_in,
      input  v1_out, v2_out, alu_op_out, alu_sign_out, reorder_buffer_tag_out,
             ready_to_execute, full, busy_count
   );

   modport slave (
      input  enable, q1_in, q2_in, v1_in, v2_in, alu_op_in, alu_sign_in,
             reorder_buffer_tag_in, flush, cdb_active, cdb_tag, cdb_data,
             dispatched_in,
      output v1_out, v2_out, alu_op_out, alu_sign_out, reorder_buffer_tag_out,
             ready_to_execute, full, busy_count
   );

endinterface

// File: rtl/rs_oldest_ready_select.sv
// Age-matrix arbiter: grants the oldest entry among those flagged ready.
// r_older[i][j] = 1 means entry i was issued before entry j.
module rs_oldest_ready_select #(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DEPTH-1:0] i_busy,
   input  logic [DEPTH-1:0] i_ready,
   input  logic [DEPTH-1:0] i_issue,
   input  logic [DEPTH-1:0] i_free,
   input  logic             i_flush,
   output logic [DEPTH-1:0] o_grant,
   output logic             o_valid
);

   logic [DEPTH-1:0] r_older [DEPTH];
   logic [DEPTH-1:0] w_blocked;

   // A new entry becomes younger than every entry still busy; a freed entry forgets all order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
      end else if (i_flush) begin
         for (int i = 0; i < DEPTH; i++) r_older[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (i_free[i] || i_free[j])
                  r_older[i][j] <= 1'b0;
               else if (i_issue[j] && i_busy[i])
                  r_older[i][j] <= 1'b1;
               else if (i_issue[i])
                  r_older[i][j] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_blocked = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (i_ready[j] && r_older[j][i]) w_blocked[i] = 1'b1;
         end
      end
   end

   assign o_grant = i_ready & ~w_blocked;
   assign o_valid = |i_ready;

endmodule

// File: rtl/reservation_station_bank.sv
// DEPTH-entry reservation station in front of one ALU: issue with CDB bypass,
// operand snooping, and oldest-ready presentation to the functional unit.
module reservation_station_bank
   import rs_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int TAG_WIDTH = 32,
   parameter int DEPTH     = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   reservation_station_bank_if.slave   bus
);

   localparam int COUNT_WIDTH = $clog2(DEPTH + 1);

   rs_entry_t r_entries [DEPTH];

   logic [DEPTH-1:0]        w_busy;
   logic [DEPTH-1:0]        w_ready;
   logic [DEPTH-1:0]        w_grant;
   logic [DEPTH-1:0]        w_issueOneHot;
   logic [DEPTH-1:0]        w_freeOneHot;
   logic                    w_anyReady;
   logic                    w_full;
   logic                    w_doIssue;
   logic                    w_doFree;
   logic                    w_foundFree;
   logic [COUNT_WIDTH-1:0]  w_count;
   rs_entry_t               w_newEntry;

   logic [XLEN-1:0]         w_v1Out;
   logic [XLEN-1:0]         w_v2Out;
   logic [ALU_OP_WIDTH-1:0] w_opOut;
   logic                    w_signOut;
   logic [TAG_WIDTH-1:0]    w_robOut;

   always_comb begin
      w_busy  = '0;
      w_ready = '0;
      w_count = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_busy[i]  = r_entries[i].busy;
         w_ready[i] = r_entries[i].busy && (r_entries[i].q1 == TAG_NONE)
                                        && (r_entries[i].q2 == TAG_NONE);
         w_count    = w_count + COUNT_WIDTH'(r_entries[i].busy);
      end
   end

   assign w_full    = &w_busy;
   assign w_doIssue = bus.enable && !w_full && !bus.flush;
   assign w_doFree  = bus.dispatched_in && w_anyReady;

   // Slot choice uses registered busy bits, so a slot freed this cycle is not reused until next.
   always_comb begin
      w_issueOneHot = '0;
      w_foundFree   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!w_busy[i] && !w_foundFree) begin
            w_issueOneHot[i] = w_doIssue;
            w_foundFree      = 1'b1;
         end
      end
   end

   assign w_freeOneHot = w_doFree ? w_grant : '0;

   always_comb begin
      w_newEntry      = '0;
      w_newEntry.busy = 1'b1;
      w_newEntry.op   = bus.alu_op_in;
      w_newEntry.sign = bus.alu_sign_in;
      w_newEntry.rob  = bus.reorder_buffer_tag_in;
      if (tagHit(bus.cdb_active, bus.q1_in, bus.cdb_tag)) begin
         w_newEntry.q1 = TAG_NONE;
         w_newEntry.v1 = bus.cdb_data;
      end else begin
         w_newEntry.q1 = bus.q1_in;
         w_newEntry.v1 = bus.v1_in;
      end
      if (tagHit(bus.cdb_active, bus.q2_in, bus.cdb_tag)) begin
         w_newEntry.q2 = TAG_NONE;
         w_newEntry.v2 = bus.cdb_data;
      end else begin
         w_newEntry.q2 = bus.q2_in;
         w_newEntry.v2 = bus.v2_in;
      end
   end

   // Flush beats everything; a dispatch beats a same-cycle snoop of the same entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (bus.flush) begin
               r_entries[i].busy <= 1'b0;
            end else if (w_freeOneHot[i]) begin
               r_entries[i].busy <= 1'b0;
            end else if (w_issueOneHot[i]) begin
               r_entries[i] <= w_newEntry;
            end else if (r_entries[i].busy) begin
               if (tagHit(bus.cdb_active, r_entries[i].q1, bus.cdb_tag)) begin
                  r_entries[i].q1 <= TAG_NONE;
                  r_entries[i].v1 <= bus.cdb_data;
               end
               if (tagHit(bus.cdb_active, r_entries[i].q2, bus.cdb_tag)) begin
                  r_entries[i].q2 <= TAG_NONE;
                  r_entries[i].v2 <= bus.cdb_data;
               end
            end
         end
      end
   end

   rs_oldest_ready_select #(
      .DEPTH (DEPTH)
   ) u_select (
      .clk     (clk),
      .reset   (reset),
      .i_busy  (w_busy),
      .i_ready (w_ready),
      .i_issue (w_issueOneHot),
      .i_free  (w_freeOneHot),
      .i_flush (bus.flush),
      .o_grant (w_grant),
      .o_valid (w_anyReady)
   );

   // Grant is one-hot or zero, so the outputs fall to 0 when nothing is ready.
   always_comb begin
      w_v1Out   = '0;
      w_v2Out   = '0;
      w_opOut   = '0;
      w_signOut = 1'b0;
      w_robOut  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_grant[i]) begin
            w_v1Out   = r_entries[i].v1;
            w_v2Out   = r_entries[i].v2;
            w_opOut   = r_entries[i].op;
            w_signOut = r_entries[i].sign;
            w_robOut  = r_entries[i].rob;
         end
      end
   end

   assign bus.v1_out                 = w_v1Out;
   assign bus.v2_out                 = w_v2Out;
   assign bus.alu_op_out             = w_opOut;
   assign bus.alu_sign_out           = w_signOut;
   assign bus.reorder_buffer_tag_out = w_robOut;
   assign bus.ready_to_execute       = w_anyReady;
   assign bus.full                   = w_full;
   assign bus.busy_count             = w_count;

endmodule
